// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte producers:
// one byte per handshake, one-cycle start strobe, tx_done timeout and inter-frame gap.
module uart_tx_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned TIMEOUT    = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_din,
    output logic                    tx_start,
    input  logic                    tx_done,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned IDW      = $clog2(NREQ);
    localparam int unsigned CNT_MAX  = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CW       = $clog2(CNT_MAX + 1);
    localparam int unsigned TO_LAST  = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
    localparam int unsigned GAP_LAST = (GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     tx_din_q, tx_din_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           err_q, err_d;
    logic           tx_start_q, tx_start_d;
    logic           busy_q, busy_d;

    logic           any_valid;
    logic [IDW-1:0] winner;
    logic           timeout;

    assign any_valid = |req_valid;
    assign timeout   = (cnt_q >= CW'(TO_LAST));

    // Rotating priority: scan last+1, last+2, ... so the previous owner goes last
    always_comb begin
        logic found;
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            int unsigned idx;
            idx = (32'(last_q) + i) % NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) begin
                    state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q >= CW'(GAP_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        tx_din_d    = tx_din_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = 1'b0;
        tx_start_d  = (state_d == S_START);
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    // Handshake is suppressed while reset is held so no byte is consumed
                    req_ready[winner] = rst;
                    tx_din_d          = req_data[32'(winner) * 8 +: 8];
                    grant_d           = winner;
                    last_d            = winner;
                end
            end
            S_START: cnt_d = '0;
            S_WAIT: begin
                if (tx_done) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    cnt_d       = '0;
                end else if (timeout) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: cnt_d = cnt_q + CW'(1);
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_din_q    <= 8'h00;
            grant_q     <= '0;
            last_q      <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            frame_cnt_q <= 16'h0000;
            err_q       <= 1'b0;
            tx_start_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            tx_din_q    <= tx_din_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
            tx_start_q  <= tx_start_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_din    = tx_din_q;
    assign tx_start  = tx_start_q;
    assign grant_id  = grant_q;
    assign busy      = busy_q;
    assign err       = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected (grant, byte) popped on tx_start.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_din;
    logic        tx_start;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        err;
    logic [15:0] frame_cnt;

    logic [3:0]  req_valid_b;
    logic [31:0] req_data_b;
    logic [3:0]  req_ready_b;
    logic [7:0]  tx_din_b;
    logic        tx_start_b;
    logic        tx_done_b;
    logic [1:0]  grant_id_b;
    logic        busy_b;
    logic        err_b;
    logic [15:0] frame_cnt_b;

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(16), .TIMEOUT(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_din(tx_din), .tx_start(tx_start), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .err(err), .frame_cnt(frame_cnt)
    );

    uart_tx_arbiter #(.NREQ(4), .GAP_CYCLES(0), .TIMEOUT(32)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_data(req_data_b),
        .req_ready(req_ready_b), .tx_din(tx_din_b), .tx_start(tx_start_b), .tx_done(tx_done_b),
        .grant_id(grant_id_b), .busy(busy_b), .err(err_b), .frame_cnt(frame_cnt_b)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    exp_t       sb[$];
    exp_t       e;
    logic [7:0] seq [4];
    int         ord [5];
    logic       ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every start strobe must match the oldest expected grant
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tx_din", 32'(tx_din), 32'(e.data));
                chk("grant_id", 32'(grant_id), 32'(e.id));
                chk("err_with_start", 32'(err), 0);
            end
        end
    end

    task automatic wait_start(output logic seen);
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("start_seen", 32'(seen), 1);
    endtask

    task automatic do_reset();
        req_valid = '0;
        tx_done   = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'(16 * i) + seq[i];
    endtask

    task automatic rr_run(input logic [3:0] v, input int n);
        int   pc [4];
        logic s;
        pc = '{0, 0, 0, 0};
        for (int i = 0; i < 4; i++) seq[i] = 8'h00;
        refresh();
        for (int k = 0; k < n; k++) begin
            sb.push_back(exp_t'{2'(ord[k]), 8'(16 * ord[k] + pc[ord[k]])});
            pc[ord[k]]++;
        end
        req_valid = v;
        for (int k = 0; k < n; k++) begin
            wait_start(s);
            if (!s) break;
            seq[ord[k]] = seq[ord[k]] + 8'd1;
            refresh();
            repeat (10) @(negedge clk);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
        req_valid = '0;
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0;
        req_valid_b = '0; req_data_b = '0; tx_done_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset mid-WAIT clears every output at once; then requester 0 wins first
        req_data = 32'hD3C2_11A0;
        req_valid = 4'b0010;
        sb.push_back(exp_t'{2'd1, 8'h11});
        wait_start(ok);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("t1_busy_wait", 32'(busy), 1);
        sb.push_back(exp_t'{2'd0, 8'hA0});
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("t1_rst_tx_start", 32'(tx_start), 0);
        chk("t1_rst_tx_din", 32'(tx_din), 0);
        chk("t1_rst_grant", 32'(grant_id), 0);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_err", 32'(err), 0);
        chk("t1_rst_frame_cnt", 32'(frame_cnt), 0);
        chk("t1_rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t1_first_grant", 32'(req_ready), 32'h1);
        wait_start(ok);
        req_valid = '0;
        @(negedge clk); tx_done = 1'b1;
        @(negedge clk); tx_done = 1'b0;
        #1 chk("t1_frame_cnt", 32'(frame_cnt), 1);
        do_reset();

        // Single request, gap latency, stray tx_done in GAP and IDLE
        req_data = 32'h00C3_0000;
        req_valid = 4'b0100;
        sb.push_back(exp_t'{2'd2, 8'hC3});
        #1 chk("t2_ready", 32'(req_ready), 32'h4);
        wait_start(ok);
        chk("t2_busy_start", 32'(busy), 1);
        @(negedge clk); tx_done = 1'b1;
        #1 chk("t2_ready_in_wait", 32'(req_ready), 0);
        @(negedge clk); tx_done = 1'b0;
        #1 chk("t2_frame_cnt", 32'(frame_cnt), 1);
        sb.push_back(exp_t'{2'd2, 8'hC3});
        repeat (15) @(negedge clk);
        #1 chk("t2_ready_gap16", 32'(req_ready), 0);
        @(negedge clk);
        #1 chk("t2_ready_gap17", 32'(req_ready), 32'h4);
        chk("t2_idle_busy", 32'(busy), 0);
        wait_start(ok);
        req_valid = '0;
        @(negedge clk); tx_done = 1'b1;
        repeat (2) @(negedge clk);
        tx_done = 1'b0;
        #1 chk("t6_stray_gap_cnt", 32'(frame_cnt), 2);
        chk("t6_stray_gap_busy", 32'(busy), 1);
        repeat (20) @(negedge clk);
        tx_done = 1'b1;
        #1 chk("t6_idle_busy", 32'(busy), 0);
        @(negedge clk); tx_done = 1'b0;
        #1 chk("t6_stray_idle_cnt", 32'(frame_cnt), 2);
        chk("t6_stray_idle_busy", 32'(busy), 0);
        do_reset();

        // Full round robin, then sparse fairness
        ord = '{0, 1, 2, 3, 0};
        rr_run(4'b1111, 5);
        do_reset();
        ord = '{0, 3, 0, 3, 0};
        rr_run(4'b1001, 4);
        do_reset();

        // Timeout: err one cycle, 32 cycles after tx_start, straight back to IDLE
        req_data = 32'h0000_5A00;
        req_valid = 4'b0010;
        sb.push_back(exp_t'{2'd1, 8'h5A});
        wait_start(ok);
        req_valid = '0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            #1 chk("t5_err", 32'(err), 32'(k == 32));
            if (k == 31) begin
                req_valid = 4'b0010;
                sb.push_back(exp_t'{2'd1, 8'h5A});
            end
        end
        chk("t5_busy", 32'(busy), 0);
        chk("t5_no_gap_ready", 32'(req_ready), 32'h2);
        chk("t5_frame_cnt", 32'(frame_cnt), 0);
        @(negedge clk);
        req_valid = '0;
        #1 chk("t5_err_clear", 32'(err), 0);
        chk("t5_restart", 32'(tx_start), 1);
        do_reset();

        // Wrap and back-to-back grants on the zero-gap instance
        force u_dut_b.frame_cnt_q = 16'hFFFE;
        @(negedge clk);
        release u_dut_b.frame_cnt_q;
        #1 chk("t6_preset", 32'(frame_cnt_b), 32'hFFFE);
        req_data_b = 32'h0000_0077;
        req_valid_b = 4'b0001;
        #1 chk("t6_ready_b", 32'(req_ready_b), 32'h1);
        @(negedge clk);
        #1 chk("t6_start_b", 32'(tx_start_b), 1);
        chk("t6_din_b", 32'(tx_din_b), 32'h77);
        chk("t6_grant_b", 32'(grant_id_b), 0);
        @(negedge clk); tx_done_b = 1'b1;
        @(negedge clk); tx_done_b = 1'b0;
        #1 chk("t6_cnt_ffff", 32'(frame_cnt_b), 32'hFFFF);
        chk("t6_b2b_ready", 32'(req_ready_b), 32'h1);
        chk("t6_b2b_busy", 32'(busy_b), 0);
        @(negedge clk);
        #1 chk("t6_b2b_start", 32'(tx_start_b), 1);
        @(negedge clk); tx_done_b = 1'b1;
        @(negedge clk); tx_done_b = 1'b0;
        req_valid_b = '0;
        #1 chk("t6_cnt_wrap", 32'(frame_cnt_b), 0);

        chk("sb_final", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
